// File: rtl/montexp_arbiter.sv
// Round-robin arbiter sharing one Montgomery exponentiation engine between NREQ requesters.
// One job at a time: grant and capture operands, pulse engine start, and return the result to the owner.
module montexp_arbiter #(
  parameter int WIDTH  = 8,
  parameter int EWIDTH = 8,
  parameter int S      = 2,
  parameter int NREQ   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ-1:0][S-1:0][WIDTH-1:0]    req_base,
  input  logic [NREQ-1:0][EWIDTH-1:0]          req_exp,
  output logic [NREQ-1:0]                      req_ready,
  output logic [NREQ-1:0]                      rsp_valid,
  output logic [S-1:0][WIDTH-1:0]              rsp_result,
  output logic                                 busy,
  output logic                                 eng_start,
  output logic [S-1:0][WIDTH-1:0]              eng_base,
  output logic [EWIDTH-1:0]                    eng_exponent,
  input  logic [S-1:0][WIDTH-1:0]              eng_result,
  input  logic                                 eng_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                    state_reg, state_next;
  logic [IW-1:0]             owner_reg, owner_next;
  logic [IW-1:0]             last_reg, last_next;
  logic [NREQ-1:0]           req_ready_reg, req_ready_next;
  logic [NREQ-1:0]           rsp_valid_reg, rsp_valid_next;
  logic [S-1:0][WIDTH-1:0]   rsp_result_reg, rsp_result_next;
  logic                      busy_reg, busy_next;
  logic                      eng_start_reg, eng_start_next;
  logic [S-1:0][WIDTH-1:0]   eng_base_reg, eng_base_next;
  logic [EWIDTH-1:0]         eng_exp_reg, eng_exp_next;

  // Candidate gi is the requester gi+1 places after the last grant, wrapping modulo NREQ.
  logic [IW-1:0]             rot_idx [NREQ];
  logic [NREQ-1:0]           rot_hit;
  logic [IW-1:0]             grant_idx;
  logic                      grant_any;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IW:0] sum;
      assign sum          = {1'b0, last_reg} + (IW+1)'(gi + 1);
      assign rot_idx[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
      assign rot_hit[gi]  = req_valid[rot_idx[gi]];
    end
  endgenerate

  assign grant_any = |req_valid;

  always_comb begin
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_hit[i]) grant_idx = rot_idx[i];
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_next       = last_reg;
    req_ready_next  = '0;
    rsp_valid_next  = '0;
    rsp_result_next = rsp_result_reg;
    busy_next       = busy_reg;
    eng_start_next  = 1'b0;
    eng_base_next   = eng_base_reg;
    eng_exp_next    = eng_exp_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          req_ready_next[grant_idx] = 1'b1;
          eng_base_next             = req_base[grant_idx];
          eng_exp_next              = req_exp[grant_idx];
          owner_next                = grant_idx;
          last_next                 = grant_idx;
          busy_next                 = 1'b1;
          state_next                = ISSUE;
        end
      end
      ISSUE: begin
        eng_start_next = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        // eng_done only counts here; earlier pulses belong to no job of ours.
        if (eng_done) begin
          rsp_result_next            = eng_result;
          rsp_valid_next[owner_reg]  = 1'b1;
          busy_next                  = 1'b0;
          state_next                 = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_reg       <= IW'(NREQ - 1);
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_result_reg <= '0;
      busy_reg       <= 1'b0;
      eng_start_reg  <= 1'b0;
      eng_base_reg   <= '0;
      eng_exp_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_reg       <= last_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_result_reg <= rsp_result_next;
      busy_reg       <= busy_next;
      eng_start_reg  <= eng_start_next;
      eng_base_reg   <= eng_base_next;
      eng_exp_reg    <= eng_exp_next;
    end
  end

  assign req_ready    = req_ready_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_result   = rsp_result_reg;
  assign busy         = busy_reg;
  assign eng_start    = eng_start_reg;
  assign eng_base     = eng_base_reg;
  assign eng_exponent = eng_exp_reg;

endmodule

// File: tb/tb_montexp_arbiter.sv
// Self-checking bench for montexp_arbiter: table-driven jobs, hand-written corner sequences,
// and a randomized phase checked against a transaction-level round-robin model.
module tb_montexp_arbiter;
  localparam int WIDTH = 8, EWIDTH = 8, S = 2, NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]                   req_valid = '0;
  logic [NREQ-1:0][S-1:0][WIDTH-1:0] req_base = '0;
  logic [NREQ-1:0][EWIDTH-1:0]       req_exp = '0;
  logic [NREQ-1:0]                   req_ready, rsp_valid;
  logic [S-1:0][WIDTH-1:0]           rsp_result, eng_base, eng_result;
  logic                              busy, eng_start, eng_done;
  logic [EWIDTH-1:0]                 eng_exponent;

  montexp_arbiter #(.WIDTH(WIDTH), .EWIDTH(EWIDTH), .S(S), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_base(req_base), .req_exp(req_exp),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exponent(eng_exponent),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  // Engine model: manual pulses for corner cases, or an automatic engine reacting to eng_start.
  logic        man_done = 1'b0, auto_en = 1'b0, auto_done, ovr_en = 1'b0;
  logic [15:0] man_result = '0, ovr_val = '0, auto_result, pend_base;
  logic [7:0]  pend_exp;
  int          lat_fix = 0, cnt;

  function automatic logic [15:0] eng_f(logic [15:0] b, logic [7:0] e);
    return {b[7:0] ^ e, b[15:8] + e} ^ 16'h5A3C;
  endfunction

  assign eng_done   = man_done | auto_done;
  assign eng_result = auto_done ? auto_result : man_result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      auto_done <= 1'b0;
      auto_result <= '0;
    end else begin
      auto_done <= 1'b0;
      if (auto_en && eng_start) begin
        cnt <= (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 8));
        pend_base <= eng_base;
        pend_exp <= eng_exponent;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          auto_done <= 1'b1;
          auto_result <= ovr_en ? ovr_val : eng_f(pend_base, pend_exp);
        end
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int onehot_idx(logic [NREQ-1:0] v);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  // Spec rule: first set bit searching upward from (last+1) mod NREQ.
  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] opb(int e, int r);
    return 16'((e + 1) * 256 + r * 16 + 5);
  endfunction
  function automatic logic [7:0] ope(int e, int r);
    return 8'(e * 4 + r + 1);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; man_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int g);
    bit seen;
    seen = 0; g = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin seen = 1; g = onehot_idx(req_ready); break; end
    end
    chk({name, "_ready_seen"}, 32'(seen), 1);
  endtask

  task automatic wait_rsp(input string name, output int o, output bit busy_bad);
    bit seen;
    seen = 0; o = -1; busy_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin seen = 1; o = onehot_idx(rsp_valid); break; end
      if (!busy) busy_bad = 1;
    end
    chk({name, "_rsp_seen"}, 32'(seen), 1);
  endtask

  task automatic do_job(input int e, input logic [3:0] v, input int grant, input logic [15:0] res);
    int g, o;
    bit bb;
    for (int r = 0; r < NREQ; r++) begin req_base[r] = opb(e, r); req_exp[r] = ope(e, r); end
    auto_en = 1'b1; ovr_en = 1'b1; ovr_val = res; lat_fix = 0;
    req_valid = v;
    wait_ready("tbl", g);
    chk("tbl_grant", g, grant);
    chk("tbl_eng_base", eng_base, opb(e, grant));
    chk("tbl_eng_exp", eng_exponent, ope(e, grant));
    req_valid = '0;
    @(negedge clk);
    chk("tbl_eng_start", eng_start, 1);
    wait_rsp("tbl", o, bb);
    chk("tbl_rsp_owner", o, grant);
    chk("tbl_rsp_result", rsp_result, res);
    chk("tbl_busy_during", bb, 0);
    chk("tbl_busy_after", busy, 0);
    $display("table job %0d valid=%b grant=%0d result=%h", e, v, g, rsp_result);
  endtask

  typedef struct { logic [3:0] valid; int grant; logic [15:0] result; } vec_t;
  typedef struct { int owner; logic [15:0] base; logic [7:0] expo; } job_t;

  initial begin
    vec_t tbl[10];
    job_t q[$];
    job_t j;
    int g, o, nready, nstart, nrsp, stall, eg, granted, x;
    bit bb, in_job, busy_bad, start_due, idle_prev, rdy_exp;
    logic [3:0] rdy_vec, rsp_vec, app_v;
    logic [15:0] sb, rres;
    logic [7:0] se;
    logic [NREQ-1:0][15:0] app_b;
    logic [NREQ-1:0][7:0] app_e;
    int mlast, seq13[4];

    tbl[0] = '{4'b1111, 0, 16'h1357}; tbl[1] = '{4'b1111, 1, 16'h2468};
    tbl[2] = '{4'b1001, 3, 16'h9ABC}; tbl[3] = '{4'b1001, 0, 16'h0F0F};
    tbl[4] = '{4'b0110, 1, 16'hF00D}; tbl[5] = '{4'b0100, 2, 16'hBEEF};
    tbl[6] = '{4'b1010, 3, 16'hCAFE}; tbl[7] = '{4'b0011, 0, 16'h7777};
    tbl[8] = '{4'b0010, 1, 16'h0001}; tbl[9] = '{4'b1101, 2, 16'hFFFE};

    // Reset state, held and just after release.
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {req_ready, rsp_valid, busy, eng_start}, 0);
    chk("rst_data", {rsp_result, eng_base, eng_exponent}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {req_ready, rsp_valid, busy, eng_start, rsp_result}, 0);

    // Single job from requester 2 with a 10-cycle engine.
    req_base[2] = 16'h0500; req_exp[2] = 8'h03;
    auto_en = 1'b1; ovr_en = 1'b1; ovr_val = 16'hAA55; lat_fix = 10;
    nready = 0; nstart = 0; nrsp = 0; in_job = 0; busy_bad = 0;
    rdy_vec = '0; rsp_vec = '0; sb = '0; se = '0; rres = '0;
    req_valid = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        nrsp++; rsp_vec = rsp_valid; rres = rsp_result; in_job = 0;
        if (busy) busy_bad = 1;
      end else if (in_job && !busy) busy_bad = 1;
      if (req_ready != '0) begin
        nready++; rdy_vec = req_ready; in_job = 1; req_valid = '0;
        if (!busy) busy_bad = 1;
      end
      if (eng_start) begin nstart++; sb = eng_base; se = eng_exponent; end
    end
    chk("single_ready_cnt", nready, 1);
    chk("single_ready_vec", rdy_vec, 4'b0100);
    chk("single_start_cnt", nstart, 1);
    chk("single_eng_base", sb, 16'h0500);
    chk("single_eng_exp", se, 8'h03);
    chk("single_rsp_cnt", nrsp, 1);
    chk("single_rsp_vec", rsp_vec, 4'b0100);
    chk("single_rsp_result", rres, 16'hAA55);
    chk("single_busy", busy_bad, 0);
    $display("single job grant=2 result=%h", rres);

    reset_dut();
    for (int e = 0; e < 10; e++) do_job(e, tbl[e].valid, tbl[e].grant, tbl[e].result);

    // All four at once: grants and responses in order 0,1,2,3.
    reset_dut();
    ovr_en = 1'b0; lat_fix = 0;
    for (int r = 0; r < NREQ; r++) begin req_base[r] = opb(20, r); req_exp[r] = ope(20, r); end
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ready("all4", g);
      chk("all4_grant", g, k);
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp("all4", o, bb);
      chk("all4_owner", o, k);
      chk("all4_result", rsp_result, eng_f(opb(20, k), ope(20, k)));
      $display("all4 job grant=%0d owner=%0d", g, o);
    end

    // Requesters 1 and 3 re-request in the response cycle: strict alternation.
    reset_dut();
    seq13[0] = 1; seq13[1] = 3; seq13[2] = 1; seq13[3] = 3;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_ready("rr13", g);
      chk("rr13_grant", g, seq13[k]);
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp("rr13", o, bb);
      chk("rr13_owner", o, seq13[k]);
      if (o >= 0) req_valid[o] = 1'b1;
      $display("rr13 job grant=%0d owner=%0d", g, o);
    end

    // Spurious eng_done in IDLE and in ISSUE.
    reset_dut();
    do_job(30, 4'b0001, 0, 16'h1234);
    auto_en = 1'b0;
    man_result = 16'hBEEF; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("idle_done_rsp", rsp_valid, 0);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_result", rsp_result, 16'h1234);
    chk("idle_done_ctl", {req_ready, eng_start}, 0);
    req_valid = 4'b0001;
    wait_ready("issue_done", g);
    chk("issue_done_grant", g, 0);
    req_valid = '0; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("issue_done_start", eng_start, 1);
    chk("issue_done_rsp", rsp_valid, 0);
    chk("issue_done_busy", busy, 1);
    chk("issue_done_result", rsp_result, 16'h1234);
    repeat (3) @(negedge clk);
    chk("wait_still_busy", {busy, rsp_valid}, 5'b10000);
    man_result = 16'h4321; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("wait_done_rsp", rsp_valid, 4'b0001);
    chk("wait_done_result", rsp_result, 16'h4321);
    $display("spurious-done job owner=0 result=%h", rsp_result);

    // Async reset mid-WAIT of requester 3's job.
    req_base[3] = 16'h3C3C; req_exp[3] = 8'h77;
    req_valid = 4'b1000;
    wait_ready("midrst", g);
    chk("midrst_grant", g, 3);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {req_ready, rsp_valid, busy, eng_start}, 0);
    chk("midrst_data", {rsp_result, eng_base, eng_exponent}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_result = 16'hDEAD; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("postrst_done_ignored", {rsp_valid, busy, rsp_result}, 0);
    auto_en = 1'b1; ovr_en = 1'b0;
    req_base[0] = 16'h0102; req_exp[0] = 8'h11;
    req_valid = 4'b1001;
    wait_ready("postrst_a", g);
    chk("postrst_first", g, 0);
    req_valid[0] = 1'b0;
    wait_rsp("postrst_a", o, bb);
    chk("postrst_owner_a", o, 0);
    chk("postrst_result_a", rsp_result, eng_f(16'h0102, 8'h11));
    wait_ready("postrst_b", g);
    chk("postrst_second", g, 3);
    req_valid[3] = 1'b0;
    wait_rsp("postrst_b", o, bb);
    chk("postrst_owner_b", o, 3);
    $display("post-reset jobs owners 0 then %0d", o);

    // Back-to-back: requester 1 waiting while requester 0's job completes.
    reset_dut();
    lat_fix = 3;
    req_valid = 4'b0011;
    wait_ready("b2b", g);
    chk("b2b_grant0", g, 0);
    req_valid[0] = 1'b0;
    wait_rsp("b2b", o, bb);
    chk("b2b_rsp_owner", o, 0);
    chk("b2b_ed_ctl", {req_ready, eng_start}, 0);
    @(negedge clk);
    chk("b2b_ready1", req_ready, 4'b0010);
    chk("b2b_ed1_rsp", {rsp_valid, eng_start}, 0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("b2b_start", eng_start, 1);
    chk("b2b_ed2_ready", req_ready, 0);
    wait_rsp("b2b1", o, bb);
    chk("b2b_rsp_owner1", o, 1);
    $display("back-to-back jobs owners 0 then %0d", o);

    // Randomized traffic against the round-robin transaction model.
    reset_dut();
    lat_fix = 0; ovr_en = 1'b0; auto_en = 1'b1;
    mlast = NREQ - 1; start_due = 0; idle_prev = 1; stall = 0;
    app_v = '0; app_b = '0; app_e = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rdy_exp = idle_prev && (app_v != '0);
      chk("rand_ready_when_idle", 32'(req_ready != '0), 32'(rdy_exp));
      chk("rand_start", eng_start, start_due);
      start_due = 0; granted = -1;
      if (rsp_valid != '0) begin
        chk("rand_rsp_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          j = q.pop_front();
          chk("rand_rsp_owner", onehot_idx(rsp_valid), j.owner);
          chk("rand_rsp_result", rsp_result, eng_f(j.base, j.expo));
          $display("rand job owner=%0d result=%h", j.owner, rsp_result);
        end
      end
      if (req_ready != '0) begin
        eg = rr_pick(mlast, app_v);
        chk("rand_grant", onehot_idx(req_ready), eg);
        if (eg >= 0) begin
          chk("rand_eng_base", eng_base, app_b[eg]);
          chk("rand_eng_exp", eng_exponent, app_e[eg]);
          q.push_back('{eg, app_b[eg], app_e[eg]});
          mlast = eg; granted = eg;
        end
        start_due = 1;
      end
      chk("rand_busy", busy, 32'(q.size() != 0));
      stall = (q.size() != 0) ? stall + 1 : 0;
      if (stall > 40) begin
        checks++; errors++;
        $display("FAIL rand_job_timeout actual=%0d cycles required<=40", stall);
        break;
      end
      idle_prev = (q.size() == 0);
      for (int r = 0; r < NREQ; r++) begin
        if (r == granted || cyc >= 1440) req_valid[r] = 1'b0;
        else if (req_valid[r]) begin
          x = $urandom_range(0, 15);
          if (x == 0) req_valid[r] = 1'b0;
          else if (x < 3) begin req_base[r] = 16'($urandom); req_exp[r] = 8'($urandom); end
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[r] = 1'b1; req_base[r] = 16'($urandom); req_exp[r] = 8'($urandom);
        end
        app_b[r] = req_base[r];
        app_e[r] = req_exp[r];
      end
      app_v = req_valid;
    end
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
